// File: rtl/fir_pkg.sv
// Shared definitions for the 3-lane parallel FIR front end: sample width,
// lane count/order and the group-assembly slot encoding.
package fir_pkg;

    localparam int DW    = 16;
    localparam int LANES = 3;

    // Lane positions inside an assembled group.
    localparam int LN_NEW = 0;
    localparam int LN_MID = 1;
    localparam int LN_OLD = 2;

    typedef enum logic [1:0] {
        PH_SLOT0 = 2'd0,
        PH_SLOT1 = 2'd1,
        PH_SLOT2 = 2'd2
    } phase_e;

    function automatic phase_e phase_advance(input phase_e ph);
        case (ph)
            PH_SLOT0: return PH_SLOT1;
            PH_SLOT1: return PH_SLOT2;
            default:  return PH_SLOT0;
        endcase
    endfunction

endpackage

// File: rtl/fir_group_holdreg.sv
// One-deep parking register for a completed group that could not be issued
// immediately (FIR busy loading coefficients, or an earlier group pending).
module fir_group_holdreg
    import fir_pkg::*;
#(
    parameter int DW = fir_pkg::DW,
    parameter int NL = fir_pkg::LANES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic                    i_drain,
    input  logic [NL-1:0][DW-1:0]   i_group,
    output logic                    o_pend,
    output logic [NL-1:0][DW-1:0]   o_group
);

    logic                  r_pend;
    logic [NL-1:0][DW-1:0] r_group;

    // NOTE: non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= 1'b0;
            r_group <= '0;
        end else if (i_load) begin
            r_pend  <= 1'b1;
            r_group <= i_group;
        end else if (i_drain) begin
            r_pend  <= 1'b0;
        end
    end

    assign o_pend  = r_pend;
    assign o_group = r_group;

endmodule

// File: rtl/fir_block_deserializer.sv
// Packs a serial valid/ready sample stream into registered 3-lane groups with
// a one-cycle start pulse; defers issue during hold, zero-pads on flush.
module fir_block_deserializer
    import fir_pkg::*;
#(
    parameter int DW = fir_pkg::DW,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 hold,
    input  logic                 flush,
    output logic signed [DW-1:0] x_out0,
    output logic signed [DW-1:0] x_out1,
    output logic signed [DW-1:0] x_out2,
    output logic                 start,
    output logic [CW-1:0]        groups_out,
    output logic                 busy
);

    phase_e                   r_phase;
    phase_e                   w_phase_nxt;
    logic [DW-1:0]            r_asm_old;
    logic [DW-1:0]            r_asm_mid;
    logic                     r_flush_req;
    logic [LANES-1:0][DW-1:0] r_x;
    logic                     r_start;
    logic [CW-1:0]            r_groups;

    logic                     w_ready;
    logic                     w_accept;
    logic                     w_flush_svc;
    logic                     w_pad;
    logic                     w_complete;
    logic                     w_issue_direct;
    logic                     w_load_pend;
    logic                     w_drain;
    logic                     w_pend;
    logic [LANES-1:0][DW-1:0] w_group;
    logic [LANES-1:0][DW-1:0] w_pend_group;

    // A second completed group can never arrive while one is parked, and
    // a pending flush freezes collection so the padded group is well defined.
    assign w_ready     = !((w_pend && (r_phase == PH_SLOT2)) ||
                           (r_flush_req && (r_phase != PH_SLOT0)));
    assign w_accept    = s_valid && w_ready;
    assign w_flush_svc = r_flush_req && !w_pend;
    assign w_pad       = w_flush_svc && (r_phase != PH_SLOT0);
    assign w_complete  = (w_accept && (r_phase == PH_SLOT2)) || w_pad;

    assign w_issue_direct = w_complete && !hold && !w_pend;
    assign w_load_pend    = w_complete && !w_issue_direct;
    assign w_drain        = w_pend && !hold;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        w_phase_nxt = r_phase;
        if (w_accept) begin
            w_phase_nxt = phase_advance(r_phase);
        end else if (w_pad) begin
            w_phase_nxt = PH_SLOT0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_SLOT0;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Missing slots of a flushed group stay at the zero default.
    always_comb begin
        w_group         = '0;
        w_group[LN_OLD] = r_asm_old;
        if (w_accept) begin
            w_group[LN_NEW] = s_data;
            w_group[LN_MID] = r_asm_mid;
        end else if (r_phase == PH_SLOT2) begin
            w_group[LN_MID] = r_asm_mid;
        end
    end

    // NOTE: data registers are reset too, so partial groups are discarded and outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm_old <= '0;
            r_asm_mid <= '0;
        end else if (w_accept) begin
            case (r_phase)
                PH_SLOT0: r_asm_old <= s_data;
                PH_SLOT1: r_asm_mid <= s_data;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_req <= 1'b0;
        end else if (flush) begin
            r_flush_req <= 1'b1;
        end else if (w_flush_svc) begin
            r_flush_req <= 1'b0;
        end
    end

    fir_group_holdreg #(
        .DW (DW),
        .NL (LANES)
    ) u_holdreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load_pend),
        .i_drain (w_drain),
        .i_group (w_group),
        .o_pend  (w_pend),
        .o_group (w_pend_group)
    );

    // Direct issue and drain are exclusive: direct issue requires no pending group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_start  <= 1'b0;
            r_groups <= '0;
        end else begin
            r_start <= 1'b0;
            if (w_issue_direct) begin
                r_x      <= w_group;
                r_start  <= 1'b1;
                r_groups <= r_groups + CW'(1);
            end else if (w_drain) begin
                r_x      <= w_pend_group;
                r_start  <= 1'b1;
                r_groups <= r_groups + CW'(1);
            end
        end
    end

    assign s_ready    = w_ready;
    assign x_out0     = r_x[LN_NEW];
    assign x_out1     = r_x[LN_MID];
    assign x_out2     = r_x[LN_OLD];
    assign start      = r_start;
    assign groups_out = r_groups;
    assign busy       = (r_phase != PH_SLOT0) || w_pend || r_flush_req;

endmodule

// File: tb/tb_fir_block_deserializer.sv
// Self-checking bench for fir_block_deserializer: directed scenarios plus a
// randomized stream scored against a sample-triplet reference model.
module tb_fir_block_deserializer;

    localparam int DW       = 16;
    localparam int CW       = 16;
    localparam int CW_SMALL = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic signed [DW-1:0] s_data = '0;
    logic                 s_valid = 1'b0;
    logic                 hold = 1'b0;
    logic                 flush = 1'b0;
    logic                 s_ready;
    logic signed [DW-1:0] x_out0, x_out1, x_out2;
    logic                 start;
    logic [CW-1:0]        groups_out;
    logic                 busy;

    // Narrow-counter instance so counter wrap is reachable in a short run.
    logic                 sm_s_ready, sm_start, sm_busy;
    logic signed [DW-1:0] sm_x0, sm_x1, sm_x2;
    logic [CW_SMALL-1:0]  sm_groups;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0]   acc_q[$];
    logic [3*DW-1:0] out_q[$];

    fir_block_deserializer #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .hold(hold), .flush(flush),
        .x_out0(x_out0), .x_out1(x_out1), .x_out2(x_out2),
        .start(start), .groups_out(groups_out), .busy(busy)
    );

    fir_block_deserializer #(.DW(DW), .CW(CW_SMALL)) dut_small (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
        .s_ready(sm_s_ready), .hold(hold), .flush(flush),
        .x_out0(sm_x0), .x_out1(sm_x1), .x_out2(sm_x2),
        .start(sm_start), .groups_out(sm_groups), .busy(sm_busy)
    );

    always #5 clk = ~clk;

    // Mid-cycle observer: records accepted samples and issued groups.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid && s_ready) acc_q.push_back(s_data);
            if (start) out_q.push_back({x_out0, x_out1, x_out2});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_valid = 1'b0; hold = 1'b0; flush = 1'b0; s_data = '0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; hold = 1'b0; flush = 1'b0;
        tick();
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", start); end
        checks++; if ({x_out0, x_out1, x_out2} !== '0) begin errors++; $display("FAIL reset_x got=%h exp=0", {x_out0, x_out1, x_out2}); end
        checks++; if (groups_out !== '0) begin errors++; $display("FAIL reset_groups got=%0d exp=0", groups_out); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic exp_start;
        for (int i = 1; i <= 6; i++) begin
            s_data = DW'(i); s_valid = 1'b1;
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got=%b exp=1", i, s_ready); end
            tick();
            exp_start = (i % 3 == 0);
            checks++; if (start !== exp_start) begin errors++; $display("FAIL stream_start%0d got=%b exp=%b", i, start, exp_start); end
            if (exp_start) begin
                checks++;
                if ({x_out0, x_out1, x_out2} !== {DW'(i), DW'(i - 1), DW'(i - 2)})
                    begin errors++; $display("FAIL stream_group%0d got=%0d,%0d,%0d exp=%0d,%0d,%0d", i, x_out0, x_out1, x_out2, i, i - 1, i - 2); end
            end
        end
        s_valid = 1'b0;
        checks++; if (groups_out !== CW'(2)) begin errors++; $display("FAIL stream_groups got=%0d exp=2", groups_out); end
    endtask

    task automatic test_hold_pending();
        hold = 1'b1;
        for (int v = 7; v <= 11; v++) begin
            s_data = DW'(v); s_valid = 1'b1;
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL hold_ready%0d got=%b exp=1", v, s_ready); end
            tick();
            checks++; if (start !== 1'b0) begin errors++; $display("FAIL hold_nostart%0d got=%b exp=0", v, start); end
        end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_drop got=%b exp=0", s_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy got=%b exp=1", busy); end
        s_data = DW'(12);
        repeat (5) begin
            tick();
            checks++; if (start !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL hold_blocked got start=%b ready=%b exp 0,0", start, s_ready); end
        end
        hold = 1'b0;
        tick();
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL drain_start got=%b exp=1", start); end
        checks++; if ({x_out0, x_out1, x_out2} !== {DW'(9), DW'(8), DW'(7)}) begin errors++; $display("FAIL drain_group got=%0d,%0d,%0d exp=9,8,7", x_out0, x_out1, x_out2); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got=%b exp=1", s_ready); end
        tick();
        s_valid = 1'b0;
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL post_drain_start got=%b exp=1", start); end
        checks++; if ({x_out0, x_out1, x_out2} !== {DW'(12), DW'(11), DW'(10)}) begin errors++; $display("FAIL post_drain_group got=%0d,%0d,%0d exp=12,11,10", x_out0, x_out1, x_out2); end
        checks++; if (groups_out !== CW'(4)) begin errors++; $display("FAIL hold_groups got=%0d exp=4", groups_out); end
    endtask

    task automatic test_flush_partial();
        s_valid = 1'b1; s_data = -DW'(5);
        tick();
        s_data = DW'(16'h8000);
        tick();
        s_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (s_ready !== 1'b0 || start !== 1'b0) begin errors++; $display("FAIL flush_wait got ready=%b start=%b exp 0,0", s_ready, start); end
        tick();
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL flush_start got=%b exp=1", start); end
        checks++; if ({x_out0, x_out1, x_out2} !== {DW'(0), DW'(16'h8000), -DW'(5)}) begin errors++; $display("FAIL flush_group got=%0d,%0d,%0d exp=0,-32768,-5", x_out0, x_out1, x_out2); end
        checks++; if (busy !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL flush_idle got busy=%b ready=%b exp 0,1", busy, s_ready); end
        checks++; if (groups_out !== CW'(5)) begin errors++; $display("FAIL flush_groups got=%0d exp=5", groups_out); end
    endtask

    task automatic test_flush_idle();
        int seen = 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL idle_flush_busy got=%b exp=1", busy); end
        repeat (3) begin tick(); if (start) seen++; end
        checks++; if (seen != 0 || groups_out !== CW'(5)) begin errors++; $display("FAIL idle_flush got starts=%0d groups=%0d exp 0,5", seen, groups_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_flush_clear got=%b exp=0", busy); end
        s_valid = 1'b1;
        s_data = DW'(21); tick();
        s_data = DW'(22); tick();
        s_data = DW'(23); flush = 1'b1; tick();
        s_valid = 1'b0; flush = 1'b0;
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL cofl_start got=%b exp=1", start); end
        checks++; if ({x_out0, x_out1, x_out2} !== {DW'(23), DW'(22), DW'(21)}) begin errors++; $display("FAIL cofl_group got=%0d,%0d,%0d exp=23,22,21", x_out0, x_out1, x_out2); end
        seen = 0;
        repeat (4) begin tick(); if (start) seen++; end
        checks++; if (seen != 0 || groups_out !== CW'(6) || busy !== 1'b0) begin errors++; $display("FAIL cofl_after got starts=%0d groups=%0d busy=%b exp 0,6,0", seen, groups_out, busy); end
    endtask

    task automatic test_reset_midgroup();
        int seen = 0;
        hold = 1'b1; s_valid = 1'b1;
        for (int v = 31; v <= 35; v++) begin s_data = DW'(v); tick(); end
        s_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({x_out0, x_out1, x_out2} !== '0 || start !== 1'b0 || groups_out !== '0) begin errors++; $display("FAIL midrst_outputs got x=%h start=%b groups=%0d exp 0", {x_out0, x_out1, x_out2}, start, groups_out); end
        tick();
        checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_ready got ready=%b busy=%b exp 1,0", s_ready, busy); end
        rst_n = 1'b1; hold = 1'b0;
        repeat (3) begin tick(); if (start) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_stale_start got=%0d exp=0", seen); end
        s_valid = 1'b1;
        for (int v = 41; v <= 43; v++) begin s_data = DW'(v); tick(); end
        s_valid = 1'b0;
        checks++; if (start !== 1'b1 || {x_out0, x_out1, x_out2} !== {DW'(43), DW'(42), DW'(41)}) begin errors++; $display("FAIL midrst_fresh got start=%b x=%0d,%0d,%0d exp 1,43,42,41", start, x_out0, x_out1, x_out2); end
        checks++; if (groups_out !== CW'(1)) begin errors++; $display("FAIL midrst_groups got=%0d exp=1", groups_out); end
    endtask

    task automatic test_random();
        int ngrp;
        int nchk;
        do_reset();
        acc_q.delete(); out_q.delete();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) hold = ~hold;
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = DW'($urandom);
            tick();
        end
        hold = 1'b0;
        for (int k = 0; k < 12 && (acc_q.size() % 3) != 0; k++) begin
            s_valid = 1'b1; s_data = DW'($urandom);
            tick();
        end
        s_valid = 1'b0;
        repeat (4) tick();
        checks++; if ((acc_q.size() % 3) != 0) begin errors++; $display("FAIL rand_tail got=%0d exp=multiple of 3", acc_q.size()); end
        ngrp = acc_q.size() / 3;
        checks++; if (out_q.size() != ngrp) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", out_q.size(), ngrp); end
        nchk = (out_q.size() < ngrp) ? out_q.size() : ngrp;
        for (int g = 0; g < nchk; g++) begin
            checks++;
            if (out_q[g] !== {acc_q[3*g+2], acc_q[3*g+1], acc_q[3*g]})
                begin errors++; $display("FAIL rand_group%0d got=%h exp=%h", g, out_q[g], {acc_q[3*g+2], acc_q[3*g+1], acc_q[3*g]}); end
        end
        checks++; if (groups_out !== CW'(ngrp)) begin errors++; $display("FAIL rand_groups got=%0d exp=%0d", groups_out, ngrp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back_wrap();
        int n_groups = 300;
        do_reset();
        s_valid = 1'b1;
        for (int i = 0; i < 3 * n_groups; i++) begin s_data = DW'(i); tick(); end
        s_valid = 1'b0;
        tick();
        checks++; if (groups_out !== CW'(n_groups)) begin errors++; $display("FAIL wrap_groups got=%0d exp=%0d", groups_out, n_groups); end
        checks++; if (sm_groups !== CW_SMALL'(n_groups % (1 << CW_SMALL))) begin errors++; $display("FAIL wrap_small got=%0d exp=%0d", sm_groups, n_groups % (1 << CW_SMALL)); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold_pending();
        test_flush_partial();
        test_flush_idle();
        test_reset_midgroup();
        test_random();
        test_back_to_back_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_block_deserializer.md
# fir_block_deserializer

Front-end packer for the 3-lane parallel FIR filter. Accepts one signed sample per handshake from a serial valid/ready stream and assembles groups of three. Each completed group is issued as a registered three-lane word with a single-cycle `start` pulse, which drives the FIR's `x_in0..2` and `start` inputs directly. The block holds off issuing while the FIR is loading coefficients, and can zero-pad a partial group on flush.

## Interface
- `DW`, 16, sample width; all data is signed two's complement.
- `CW`, 16, width of the issued-group counter.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `s_data`  in  DW  serial input sample.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  block can accept a sample this cycle; combinational from state only, never from `s_valid`.
- `hold`  in  1  issue inhibit; tied to the FIR's `load_coeff`.
- `flush`  in  1  single-cycle request to close a partial group with zero padding.
- `x_out0`  out  DW  newest sample of the issued group.
- `x_out1`  out  DW  middle sample of the issued group.
- `x_out2`  out  DW  oldest sample of the issued group.
- `start`  out  1  one-cycle pulse; `x_out0..2` are valid in the same cycle.
- `groups_out`  out  CW  count of issued groups, wraps modulo 2^CW.
- `busy`  out  1  high when `phase != 0`, `pend`, or `flush_req` is set.

## Operation
- A sample is accepted on any cycle where `s_valid && s_ready`.
- `phase` is a 2-bit counter (0, 1, 2) giving the slot of the next sample.
  - Slot 0 stores to `asm_old`; slot 1 stores to `asm_mid`.
  - Slot 2 completes the group as {newest = `s_data`, middle = `asm_mid`, oldest = `asm_old`}.
  - `phase` wraps 2→0 on the completing accept.
- Group issue path, evaluated on the cycle a group completes:
  - If `hold` is low and `pend` is 0: load `x_out0..2` and pulse `start` next cycle.
  - Otherwise: store the group into the pending registers and set `pend`.
- While `pend` is set, `start` fires on the first cycle after a clock edge at which `hold` was sampled low. The pending group moves to `x_out`, `pend` clears on the same edge, and the pulse is one cycle long.
- Collection continues while `pend` is set. Slots 0 and 1 still accept, but `s_ready` = !(`pend` && `phase`==2), so a second completed group is never overwritten.
- `x_out0..2` keep their last issued values between pulses.
- Flush:
  - A `flush` pulse sets sticky `flush_req`.
  - `flush_req` is serviced on the first cycle with `pend` = 0.
  - If `phase` is 1 or 2 at that point, the group completes with zeros in the missing slots. With `phase`=1: newest=0, mid=0, oldest=`asm_old`. With `phase`=2: newest=0, mid=`asm_mid`, oldest=`asm_old`. The group then follows the normal issue path and `phase` returns to 0.
  - If `phase` is 0 at that point, `flush_req` simply clears and nothing is issued.
  - `s_ready` is low while `flush_req` is set and `phase` != 0.
- If a flush and an accept land in the same cycle, the sample is taken first and the flush applies to the resulting `phase`.
- `groups_out` increments on each `start` pulse.
- Arithmetic: data is moved only, never arithmetically modified; the padding value is 0.

## Timing
- Reset values: `x_out0..2` = 0, `start` = 0, `groups_out` = 0, `phase` = 0, `pend` = 0, `flush_req` = 0, and `asm_*` / pending registers = 0. After reset, `s_ready` = 1 and `busy` = 0.
- Latency: completing accept at edge N gives `start` high in the cycle after edge N, i.e. one cycle.
- Throughput: one sample per cycle sustained, so one `start` every 3 cycles with `hold` low.
- A reset assertion mid-group or mid-pending discards all partial and pending data immediately; no `start` pulse follows.
- `hold` rising in the same cycle a group completes causes deferral: that group goes to `pend`.

## Structure
- Shared package `fir_pkg`: `DW`, the lane count constant `LANES` = 3, and the `phase` encoding.
- Sub-module `fir_group_holdreg`: the one-deep pending register with its `pend` flag and load/drain handshake.
- Expected size: about 150–220 lines of RTL.

## Test plan
- Stream 1, 2, 3, 4, 5, 6 with `hold` low → `start` pulses 1 cycle after samples 3 and 6, with (x0,x1,x2) = (3,2,1) then (6,5,4); `groups_out` = 2.
- Assert `hold` for 10 cycles while streaming 7..12 → group (9,8,7) pends; `s_ready` drops after sample 11 is accepted. After `hold` falls: `start` (9,8,7), then sample 12 is accepted, then `start` (12,11,10).
- Send -5, -32768, then pulse `flush` → `start` with (0,-32768,-5); `phase` returns to 0 and `busy` drops.
- Pulse `flush` at `phase` 0 → no `start` pulse and `groups_out` unchanged. Then pulse `flush` in the same cycle as the 3rd sample is accepted → exactly one `start`, with no padding.
- Assert `rst_n` low after 2 samples with a group pending → all outputs are 0 and `s_ready` = 1 on the next cycle; the next 3 samples form a fresh group.
- Send 70000 groups → `groups_out` wraps to 70000 mod 65536 = 4464.
